// File: rtl/rc_tag_arbiter.sv
// Tag pool and round-robin tag allocator for PCIe non-posted reads (DMA clock domain).
// Optional macro RC_TAG_STAT_EN adds allocation count and peak-occupancy statistics.
module rc_tag_arbiter #(
    parameter  int TAG_NUM = 32,
    parameter  int REQ_NUM = 2,
    localparam int TAG_W   = $clog2(TAG_NUM)
) (
    input  logic               dma_clk,
    input  logic               dma_rst_n,
    input  logic [REQ_NUM-1:0] req_valid,
    output logic [REQ_NUM-1:0] req_ready,
    output logic [TAG_W-1:0]   req_tag,
    input  logic               cpl_valid,
    input  logic [TAG_W-1:0]   cpl_tag,
    input  logic               cpl_done,
    output logic [TAG_W:0]     tag_free_cnt,
    output logic               idle,
`ifdef RC_TAG_STAT_EN
    output logic [31:0]        stat_alloc_cnt,
    output logic [TAG_W:0]     stat_max_busy,
`endif
    output logic               err_dbl_free
);

    localparam int RR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [TAG_NUM-1:0] busy_r;
    logic [TAG_W:0]     free_cnt_r;
    logic               idle_r;
    logic               err_r;
    logic [RR_W-1:0]    rr_ptr_r;

    logic [TAG_W-1:0]   free_tag_s;
    logic [REQ_NUM-1:0] grant_s;
    logic [RR_W-1:0]    grant_idx_s;
    logic               alloc_s;
    logic               rel_s;
    logic               rel_hit_s;
    logic [TAG_NUM-1:0] busy_nxt_s;
    logic [TAG_W:0]     free_nxt_s;
    logic [RR_W-1:0]    rr_nxt_s;

    // Lowest-indexed free tag from the registered bitmap.
    always_comb begin
        logic tag_found;
        free_tag_s = {TAG_W{1'b0}};
        tag_found  = 1'b0;
        for (int i = 0; i < TAG_NUM; i++) begin
            free_tag_s = (!tag_found && !busy_r[i]) ? TAG_W'(i) : free_tag_s;
            tag_found  = tag_found | ~busy_r[i];
        end
    end

    // Round-robin search starting at rr_ptr_r; reset input gates grants while asserted.
    always_comb begin
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        grant_idx_s = {RR_W{1'b0}};
        grant_s     = {REQ_NUM{1'b0}};
        for (int i = 0; i < REQ_NUM; i++) begin
            idx         = (int'(rr_ptr_r) + i) % REQ_NUM;
            grant_idx_s = (!found && req_valid[idx]) ? RR_W'(idx) : grant_idx_s;
            found       = found | req_valid[idx];
        end
        if (found && (free_cnt_r != {(TAG_W+1){1'b0}}) && dma_rst_n) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {REQ_NUM{1'b0}};
        end
    end

    assign req_ready = grant_s;
    assign req_tag   = free_tag_s;
    assign alloc_s   = |grant_s;
    assign rel_s     = cpl_valid & cpl_done;
    assign rel_hit_s = rel_s & busy_r[cpl_tag];

    // Next bitmap/count; a grant of the same tag a release names wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (rel_s) begin
            busy_nxt_s[cpl_tag] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (alloc_s) begin
            busy_nxt_s[free_tag_s] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        free_nxt_s = free_cnt_r - (TAG_W+1)'(alloc_s) + (TAG_W+1)'(rel_hit_s);
        if (grant_idx_s == RR_W'(REQ_NUM - 1)) begin
            rr_nxt_s = {RR_W{1'b0}};
        end else begin
            rr_nxt_s = grant_idx_s + RR_W'(1);
        end
    end

    // Pool state, status and round-robin pointer.
    always_ff @(posedge dma_clk or negedge dma_rst_n) begin
        if (!dma_rst_n) begin
            busy_r     <= {TAG_NUM{1'b0}};
            free_cnt_r <= (TAG_W+1)'(TAG_NUM);
            idle_r     <= 1'b1;
            err_r      <= 1'b0;
            rr_ptr_r   <= {RR_W{1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            free_cnt_r <= free_nxt_s;
            idle_r     <= (free_nxt_s == (TAG_W+1)'(TAG_NUM));
            err_r      <= err_r | (rel_s & ~busy_r[cpl_tag]);
            if (alloc_s) begin
                rr_ptr_r <= rr_nxt_s;
            end
        end
    end

    assign tag_free_cnt = free_cnt_r;
    assign idle         = idle_r;
    assign err_dbl_free = err_r;

`ifdef RC_TAG_STAT_EN
    logic [31:0]    stat_alloc_r;
    logic [TAG_W:0] stat_max_r;
    logic [TAG_W:0] busy_cnt_nxt_s;

    assign busy_cnt_nxt_s = (TAG_W+1)'(TAG_NUM) - free_nxt_s;

    // Grant counter (wraps) and peak outstanding-tag tracker.
    always_ff @(posedge dma_clk or negedge dma_rst_n) begin
        if (!dma_rst_n) begin
            stat_alloc_r <= 32'd0;
            stat_max_r   <= {(TAG_W+1){1'b0}};
        end else begin
            stat_alloc_r <= stat_alloc_r + 32'(alloc_s);
            if (busy_cnt_nxt_s > stat_max_r) begin
                stat_max_r <= busy_cnt_nxt_s;
            end
        end
    end

    assign stat_alloc_cnt = stat_alloc_r;
    assign stat_max_busy  = stat_max_r;
`endif

endmodule

// File: doc/rc_tag_arbiter.md
RC_TAG_ARBITER -- requirements
Module: rc_tag_arbiter

Interface
REQ-001 Parameter: TAG_NUM, default 32, number of PCIe non-posted read tags managed; fixed power of two; TAG_W = log2(TAG_NUM) = 5.
REQ-002 Parameter: REQ_NUM, default 2, number of read requesters sharing the tag pool.
REQ-003 dma_clk  in  1  block clock, DMA domain; same domain as the RC async FIFO read side. Single clock.
REQ-004 dma_rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  REQ_NUM  per-requester tag request.
REQ-006 req_ready  out  REQ_NUM  per-requester grant, one-hot or zero.
REQ-007 req_tag  out  TAG_W  allocated tag; valid while any req_ready bit is high.
REQ-008 cpl_valid  in  1  RC completion beat accepted (dma_axis_rc_tvalid & tready).
REQ-009 cpl_tag  in  TAG_W  tag field of the completion descriptor.
REQ-010 cpl_done  in  1  request-completed flag; meaningful only with cpl_valid.
REQ-011 tag_free_cnt  out  TAG_W+1  number of free tags.
REQ-012 idle  out  1  high when all tags are free.
REQ-013 err_dbl_free  out  1  sticky; set on a release of an already-free tag.

Function
REQ-014 Tag state: one TAG_NUM-bit busy bitmap; bit=1 means outstanding.
REQ-015 Allocation: the lowest-indexed free tag is offered, combinationally from the registered bitmap.
REQ-016 Arbitration: round-robin among asserted req_valid; at most one grant per cycle; req_ready is combinational (zero added latency).
REQ-017 RR pointer: after each grant, points to the granted requester + 1 (mod REQ_NUM); unchanged when there is no grant.
REQ-018 No grant when tag_free_cnt == 0; all req_ready bits are low.
REQ-019 Handshake: req_valid & req_ready sets the busy bit at the next edge; req_valid is not required to hold after grant.
REQ-020 Release: cpl_valid & cpl_done clears busy[cpl_tag] at the next edge.
REQ-021 A freed tag is not reallocatable in the same cycle; there is no bypass.
REQ-022 Simultaneous grant and release of different tags in one cycle: tag_free_cnt is unchanged.
REQ-023 Simultaneous grant of a tag while a release names that same tag (only possible when it is already free): the grant wins, the bit ends up set, and err_dbl_free is set.
REQ-024 Release of a free tag: the bitmap is unchanged and err_dbl_free is set.
REQ-025 tag_free_cnt and idle are registered and consistent with the bitmap every cycle; the count saturates at neither bound.
REQ-026 cpl_valid without cpl_done has no effect.

Reset
REQ-027 On dma_rst_n low, asynchronously:
- bitmap = 0
- tag_free_cnt = TAG_NUM
- idle = 1
- err_dbl_free = 0
- RR pointer = 0
- req_ready = 0 during reset
REQ-028 Reset asserted mid-operation drops all outstanding tags; late completions arriving afterwards set err_dbl_free.

Configuration
REQ-029 Macro RC_TAG_STAT_EN adds outputs stat_alloc_cnt (32) and stat_max_busy (TAG_W+1), both reset to 0.
- stat_alloc_cnt increments per grant and wraps at 2^32.
- stat_max_busy holds the peak of TAG_NUM - tag_free_cnt.
REQ-030 Without RC_TAG_STAT_EN, these ports and registers do not exist; all other behaviour is identical.

Verification
REQ-031 After reset, req_valid=2'b01 -> req_ready=2'b01, req_tag=0; next cycle tag_free_cnt=31 and idle=0.
REQ-032 req_valid=2'b11 held for 4 cycles -> grants alternate 01,10,01,10 with tags 0,1,2,3; tag_free_cnt=28.
REQ-033 Allocate all 32 tags -> req_ready=0 while req_valid=1; cpl_valid=1, cpl_done=1, cpl_tag=7 -> next cycle grant with req_tag=7.
REQ-034 In one cycle, grant tag 5 and release tag 3 -> tag_free_cnt is unchanged; next offered tag is 3.
REQ-035 Release of tag 9 while free -> err_dbl_free=1 and stays 1 until reset; cpl_done=0 with cpl_valid=1 -> no change.
REQ-036 Assert dma_rst_n=0 with 10 tags busy -> tag_free_cnt=32 and idle=1 immediately; with RC_TAG_STAT_EN, stat_max_busy=0.
